// File: rtl/switch_reg_pkg.sv
// Shared constants and FSM encoding for the SPI register-table front-end.
package switch_reg_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 7;
  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned FRAME_LEN      = 24;

  // Frame field positions (MSB first on the wire)
  localparam int unsigned RW_BIT   = 23;
  localparam int unsigned ADDR_MSB = 22;
  localparam int unsigned ADDR_LSB = 16;
  localparam int unsigned DATA_MSB = 15;
  localparam int unsigned DATA_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RFETCH,
    ST_RDATA,
    ST_WDATA,
    ST_DONE
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with registered rise/fall pulses.
// All flops reset low, so a pin held low through reset never yields a false fall.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q, rise_q, fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave turning 24-bit frames into register-table writes and reads.
module spi_reg_slave
  import switch_reg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wr,
  output logic [DATA_WIDTH-1:0] din,
  output logic [ADDR_WIDTH-1:0] addr_r,
  input  logic [DATA_WIDTH-1:0] spi_dout,
  output logic                  busy,
  output logic                  frame_abort
);

  localparam int unsigned CMD_BITS   = 1 + ADDR_WIDTH;
  localparam int unsigned FRAME_BITS = CMD_BITS + DATA_WIDTH;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int unsigned LAT_W      = $clog2(RD_LAT + 2);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge u_sync_sclk (
    .clk(clk), .rst(rst), .d_i(spi_sclk),
    .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync_edge u_sync_cs (
    .clk(clk), .rst(rst), .d_i(spi_cs_n),
    .q_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_sync_edge u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(spi_mosi),
    .q_o(mosi_sync), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [DATA_WIDTH-2:0]   rx_q, rx_d;
  logic [DATA_WIDTH-1:0]   tx_q, tx_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, addr_r_q, addr_r_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic                    miso_q, miso_d, oe_q, oe_d, wr_q, wr_d;
  logic                    busy_q, busy_d, abort_q, abort_d, cs_seen_q, cs_seen_d;
  logic                    frame_active;

  assign cnt_inc      = (cnt_q == CNT_W'(FRAME_BITS)) ? cnt_q : cnt_q + CNT_W'(1);
  assign frame_active = state_q inside {ST_CMD, ST_RFETCH, ST_RDATA, ST_WDATA};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      lat_q      <= '0;
      cmd_addr_q <= '0;
      addr_q     <= '0;
      addr_r_q   <= '0;
      din_q      <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
      cs_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      lat_q      <= lat_d;
      cmd_addr_q <= cmd_addr_d;
      addr_q     <= addr_d;
      addr_r_q   <= addr_r_d;
      din_q      <= din_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
      cs_seen_q  <= cs_seen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    lat_d      = lat_q;
    cmd_addr_d = cmd_addr_q;
    addr_d     = addr_q;
    addr_r_d   = addr_r_q;
    din_d      = din_q;
    miso_d     = miso_q;
    wr_d       = 1'b0;
    abort_d    = 1'b0;
    // busy only counts once cs_n has been seen high after reset
    cs_seen_d  = cs_seen_q | cs_sync;
    busy_d     = cs_seen_q & ~cs_sync;

    if (frame_active && cs_rise) begin
      state_d = ST_IDLE;
      abort_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d = ST_CMD;
            cnt_d   = '0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            rx_d  = {rx_q[DATA_WIDTH-3:0], mosi_sync};
            cnt_d = cnt_inc;
            if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
              cmd_addr_d = {rx_q[ADDR_WIDTH-2:0], mosi_sync};
              if (rx_q[ADDR_WIDTH-1]) begin
                state_d = ST_WDATA;
              end else begin
                addr_r_d = {rx_q[ADDR_WIDTH-2:0], mosi_sync};
                lat_d    = '0;
                state_d  = ST_RFETCH;
              end
            end
          end
        end
        ST_RFETCH: begin
          if (sclk_rise) cnt_d = cnt_inc;
          if (lat_q == LAT_W'(RD_LAT)) begin
            tx_d    = spi_dout;
            state_d = ST_RDATA;
          end else begin
            lat_d = lat_q + LAT_W'(1);
          end
        end
        ST_RDATA: begin
          if (sclk_fall) begin
            miso_d = tx_q[DATA_WIDTH-1];
            tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
          end
          if (sclk_rise) begin
            cnt_d = cnt_inc;
            if (cnt_q == CNT_W'(FRAME_BITS - 1)) state_d = ST_DONE;
          end
        end
        ST_WDATA: begin
          if (sclk_rise) begin
            rx_d  = {rx_q[DATA_WIDTH-3:0], mosi_sync};
            cnt_d = cnt_inc;
            if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
              wr_d    = 1'b1;
              addr_d  = cmd_addr_q;
              din_d   = {rx_q, mosi_sync};
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (cs_rise) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    oe_d = (state_d == ST_RDATA);
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign addr        = addr_q;
  assign wr          = wr_q;
  assign din         = din_q;
  assign addr_r      = addr_r_q;
  assign busy        = busy_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave with a small register-table model behind it.
`timescale 1ns/1ps
module tb_spi_reg_slave;

  localparam int HALF = 100;

  logic        clk, rst, spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe, wr, busy, frame_abort;
  logic [6:0]  addr, addr_r;
  logic [15:0] din, spi_dout;

  spi_reg_slave dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .addr(addr), .wr(wr), .din(din), .addr_r(addr_r), .spi_dout(spi_dout),
    .busy(busy), .frame_abort(frame_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register table model: writes land on wr, reads appear two cycles after addr_r
  logic [15:0] mem [128];
  logic [6:0]  a1, a2;
  int          wr_cnt = 0, abort_cnt = 0;
  logic [6:0]  last_addr;
  logic [15:0] last_din;

  always @(posedge clk) begin
    a1 <= addr_r;
    a2 <= a1;
  end
  assign spi_dout = mem[a2];

  always @(negedge clk) begin
    if (wr) begin
      wr_cnt++;
      last_addr = addr;
      last_din  = din;
      mem[addr] = din;
    end
    if (frame_abort) abort_cnt++;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic spi_xfer(input logic [23:0] frame, input int nbits, input bit is_read,
                          input int rst_at, output logic [15:0] rdata, output int oe_bad);
    logic [23:0] f;
    logic        exp_oe;
    f      = frame;
    rdata  = '0;
    oe_bad = 0;
    spi_cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 24) ? f[23-i] : 1'b1;
      #HALF;
      if (i == rst_at) begin
        rst = 1'b1;
        #30;
        chk("rst_addr",   32'(addr),        32'h0);
        chk("rst_din",    32'(din),         32'h0);
        chk("rst_addr_r", 32'(addr_r),      32'h0);
        chk("rst_wr",     32'(wr),          32'h0);
        chk("rst_busy",   32'(busy),        32'h0);
        chk("rst_oe",     32'(spi_miso_oe), 32'h0);
        chk("rst_miso",   32'(spi_miso),    32'h0);
        chk("rst_abort",  32'(frame_abort), 32'h0);
        rst = 1'b0;
        #20;
      end
      spi_sclk = 1'b1;
      if (i == 2) chk("busy_in_frame", 32'(busy), 32'h1);
      if (i >= 8 && i < 24) rdata = {rdata[14:0], spi_miso};
      exp_oe = is_read && (i >= 8) && (i < 24);
      if (spi_miso_oe !== exp_oe) oe_bad++;
      #HALF;
      spi_sclk = 1'b0;
    end
    #HALF;
    spi_cs_n = 1'b1;
    #(4*HALF);
  endtask

  logic [15:0] rd;
  int          oeb, w0, ab0;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'h0;
    mem[0] = 16'h0013;
    rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_miso",   32'(spi_miso),    32'h0);
    chk("reset_oe",     32'(spi_miso_oe), 32'h0);
    chk("reset_addr",   32'(addr),        32'h0);
    chk("reset_wr",     32'(wr),          32'h0);
    chk("reset_din",    32'(din),         32'h0);
    chk("reset_addr_r", 32'(addr_r),      32'h0);
    chk("reset_busy",   32'(busy),        32'h0);
    chk("reset_abort",  32'(frame_abort), 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Write 0x10 <- 0x00F0
    w0 = wr_cnt; ab0 = abort_cnt;
    spi_xfer(24'h9000F0, 24, 1'b0, -1, rd, oeb);
    chk("w1_wr_count", 32'(wr_cnt - w0),    32'd1);
    chk("w1_addr",     32'(last_addr),      32'h10);
    chk("w1_din",      32'(last_din),       32'h00F0);
    chk("w1_abort",    32'(abort_cnt - ab0), 32'd0);
    chk("w1_oe",       32'(oeb),            32'd0);
    chk("w1_addr_hold", 32'(addr),          32'h10);
    chk("w1_busy_after", 32'(busy),         32'h0);

    // Read 0x00 (table holds 0x0013), junk data bits from master
    w0 = wr_cnt; ab0 = abort_cnt;
    spi_xfer(24'h00A5A5, 24, 1'b1, -1, rd, oeb);
    chk("r1_data",     32'(rd),             32'h0013);
    chk("r1_oe",       32'(oeb),            32'd0);
    chk("r1_addr_r",   32'(addr_r),         32'h00);
    chk("r1_wr",       32'(wr_cnt - w0),    32'd0);
    chk("r1_abort",    32'(abort_cnt - ab0), 32'd0);
    chk("r1_oe_after", 32'(spi_miso_oe),    32'h0);

    // Back-to-back write then read of 0x13
    w0 = wr_cnt;
    spi_xfer(24'h9300F1, 24, 1'b0, -1, rd, oeb);
    spi_xfer(24'h130000, 24, 1'b1, -1, rd, oeb);
    chk("b2b_wr_count", 32'(wr_cnt - w0),   32'd1);
    chk("b2b_rdata",   32'(rd),             32'h00F1);
    chk("b2b_oe",      32'(oeb),            32'd0);
    chk("b2b_addr_r",  32'(addr_r),         32'h13);

    // Abort after 12 bits, then a full write to 0x16
    w0 = wr_cnt; ab0 = abort_cnt;
    spi_xfer(24'h9600AA, 12, 1'b0, -1, rd, oeb);
    chk("abort_wr",    32'(wr_cnt - w0),    32'd0);
    chk("abort_pulse", 32'(abort_cnt - ab0), 32'd1);
    chk("abort_addr_hold", 32'(addr),       32'h13);
    w0 = wr_cnt; ab0 = abort_cnt;
    spi_xfer(24'h9600F2, 24, 1'b0, -1, rd, oeb);
    chk("post_abort_wr", 32'(wr_cnt - w0),  32'd1);
    chk("post_abort_addr", 32'(last_addr),  32'h16);
    chk("post_abort_din", 32'(last_din),    32'h00F2);
    chk("post_abort_abort", 32'(abort_cnt - ab0), 32'd0);

    // Reset at bit 20 of a write to 0x18, then resend
    w0 = wr_cnt; ab0 = abort_cnt;
    spi_xfer(24'h981234, 24, 1'b0, 20, rd, oeb);
    chk("rstf_wr",     32'(wr_cnt - w0),    32'd0);
    chk("rstf_abort",  32'(abort_cnt - ab0), 32'd0);
    chk("rstf_addr",   32'(addr),           32'h0);
    w0 = wr_cnt;
    spi_xfer(24'h981234, 24, 1'b0, -1, rd, oeb);
    chk("rstf2_wr",    32'(wr_cnt - w0),    32'd1);
    chk("rstf2_addr",  32'(last_addr),      32'h18);
    chk("rstf2_din",   32'(last_din),       32'h1234);

    // 30 sclk edges in a write frame to 0x1A, then read it back
    w0 = wr_cnt; ab0 = abort_cnt;
    spi_xfer(24'h9A00F3, 30, 1'b0, -1, rd, oeb);
    chk("long_wr",     32'(wr_cnt - w0),    32'd1);
    chk("long_addr",   32'(last_addr),      32'h1A);
    chk("long_din",    32'(last_din),       32'h00F3);
    chk("long_abort",  32'(abort_cnt - ab0), 32'd0);
    spi_xfer(24'h1A0000, 24, 1'b1, -1, rd, oeb);
    chk("long_rdata",  32'(rd),             32'h00F3);
    chk("long_addr_r", 32'(addr_r),         32'h1A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
